unidade_load_store: RTL and testbench

//  Initiator side of the data-memory port. Takes one load/store request at a time from the

---
 rtl/unidade_load_store.sv | 179 +++++++++++++++++
 tb/tb_unidade_load_store.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/unidade_load_store.sv
// Data-memory initiator: runs one load/store at a time against a word-addressed memory.
// Sub-word stores use read-modify-write; sub-word loads are extracted and extended here.
module unidade_load_store #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              memwrite,
  output logic              memread,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 2;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                busy_d, done_d, err_d, memread_d, memwrite_d;

  logic                funct_bad_c, misalign_c, range_bad_c, req_err_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic [DATA_W-1:0]   load_ext_c;
  logic [DATA_W-1:0]   lane_mask_c, lane_data_c, merged_c;

  // Request legality, evaluated on the live request while idle
  always_comb begin
    funct_bad_c = 1'b0;
    if (we) begin
      funct_bad_c = !(funct3 == F_B || funct3 == F_H || funct3 == F_W);
    end else begin
      funct_bad_c = !(funct3 == F_B || funct3 == F_H || funct3 == F_W ||
                      funct3 == F_BU || funct3 == F_HU);
    end
    misalign_c  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    range_bad_c = |addr[31:ADDR_W+2];
    req_err_c   = funct_bad_c || misalign_c || range_bad_c;
  end

  // Lane extraction for loads (little-endian lanes)
  always_comb begin
    byte_c     = 8'(mem_rdata >> {off_q, 3'b000});
    half_c     = 16'(mem_rdata >> {off_q[1], 4'b0000});
    load_ext_c = mem_rdata;
    case (funct3_q)
      F_B:     load_ext_c = {{24{byte_c[7]}}, byte_c};
      F_H:     load_ext_c = {{16{half_c[15]}}, half_c};
      F_BU:    load_ext_c = {24'h000000, byte_c};
      F_HU:    load_ext_c = {16'h0000, half_c};
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Lane merge for sub-word stores; bytes outside the lane keep the read value
  always_comb begin
    lane_mask_c = (funct3_q == F_H) ? (DATA_W'(16'hFFFF) << {off_q, 3'b000})
                                    : (DATA_W'(8'hFF) << {off_q, 3'b000});
    lane_data_c = wdata_q << {off_q, 3'b000};
    merged_c    = (mem_rdata & ~lane_mask_c) | (lane_data_c & lane_mask_c);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata;
    mem_wdata_d = mem_wdata;
    mem_addr_d  = mem_addr;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = addr[ADDR_W+1:2];
          if (req_err_c) begin
            state_d = S_ERR;
          end else if (we && (funct3 == F_W)) begin
            mem_wdata_d = wdata;
            state_d     = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_RDW;
      S_RDW: begin
        if (we_q) begin
          mem_wdata_d = merged_c;
          state_d     = S_WR;
        end else begin
          rdata_d = load_ext_c;
          state_d = S_DONE;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are pure decodes of the next state, then registered
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE) || (state_d == S_ERR);
    err_d      = (state_d == S_ERR);
    memread_d  = (state_d == S_RD);
    memwrite_d = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      mem_wdata <= '0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rdata     <= rdata_d;
      mem_wdata <= mem_wdata_d;
      mem_addr  <= mem_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      memread   <= memread_d;
      memwrite  <= memwrite_d;
    end
  end

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a 32-word registered memory model.
module tb_unidade_load_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        memwrite, memread;
  logic [31:0] mem_rdata;

  logic [31:0] mem [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  int n_assert = 0;
  int n_fail   = 0;

  int          lat, nrd, nwr, ndone, first_done, second_done;
  logic        e, both;
  logic [4:0]  rdaddr;

  always #5 clk = ~clk;

  unidade_load_store #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .memwrite(memwrite), .memread(memread), .mem_rdata(mem_rdata)
  );

  // Word memory: write and read both sampled on the rising edge
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (memwrite) mem[mem_addr] <= mem_wdata;
    if (memread) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  // Issue one request in an idle cycle and watch it complete (bounded)
  task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    lat = -1; nrd = 0; nwr = 0; both = 1'b0; e = 1'b0; rdaddr = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (memread) begin nrd++; rdaddr = mem_addr; end
      if (memwrite) nwr++;
      if (memread && memwrite) both = 1'b1;
      if (done) begin lat = i; e = err; break; end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_strobes", {30'd0, memread, memwrite}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    preload(5'd3, 32'hDEADBEEF);
    preload(5'd2, 32'h11223344);
    @(negedge clk); rst_n = 1'b1;

    // LW word 3
    run(1'b0, 3'b010, 32'h0000_000C, 32'h0);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_err", 32'(e), 32'd0);
    chk("lw_reads", 32'(nrd), 32'd1);
    chk("lw_writes", 32'(nwr), 32'd0);
    chk("lw_rd_addr", 32'(rdaddr), 32'd3);
    chk("lw_rdata", rdata, 32'hDEADBEEF);

    // Sub-word loads
    preload(5'd3, 32'h80FF7F01);
    run(1'b0, 3'b000, 32'h0000_000D, 32'h0);
    chk("lb_rdata", rdata, 32'h0000007F);
    chk("lb_latency", 32'(lat), 32'd3);
    run(1'b0, 3'b100, 32'h0000_000D, 32'h0);
    chk("lbu_rdata", rdata, 32'h0000007F);
    run(1'b0, 3'b001, 32'h0000_000E, 32'h0);
    chk("lh_rdata", rdata, 32'hFFFF80FF);
    run(1'b0, 3'b101, 32'h0000_000E, 32'h0);
    chk("lhu_rdata", rdata, 32'h000080FF);
    run(1'b0, 3'b000, 32'h0000_000F, 32'h0);
    chk("lb_lane3", rdata, 32'hFFFFFF80);

    // Sub-word stores via read-modify-write
    run(1'b1, 3'b000, 32'h0000_0009, 32'h123456AB);
    chk("sb_latency", 32'(lat), 32'd4);
    chk("sb_err", 32'(e), 32'd0);
    chk("sb_reads", 32'(nrd), 32'd1);
    chk("sb_writes", 32'(nwr), 32'd1);
    chk("sb_no_overlap", 32'(both), 32'd0);
    chk("sb_mem2", mem[2], 32'h1122AB44);
    chk("sb_rdata_hold", rdata, 32'hFFFFFF80);
    run(1'b1, 3'b001, 32'h0000_000A, 32'h0000CAFE);
    chk("sh_latency", 32'(lat), 32'd4);
    chk("sh_mem2", mem[2], 32'hCAFEAB44);

    // Full-word store skips the read
    run(1'b1, 3'b010, 32'h0000_0010, 32'hA5A55A5A);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_reads", 32'(nrd), 32'd0);
    chk("sw_writes", 32'(nwr), 32'd1);
    chk("sw_mem4", mem[4], 32'hA5A55A5A);

    // Rejected requests
    run(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    chk("err_lw_mis", {lat[15:0], 15'd0, e}, {16'd1, 15'd0, 1'b1});
    chk("err_lw_mis_mem", 32'(nrd + nwr), 32'd0);
    run(1'b1, 3'b001, 32'h0000_0003, 32'hFFFF);
    chk("err_sh_mis", {lat[15:0], 15'd0, e}, {16'd1, 15'd0, 1'b1});
    chk("err_sh_mis_mem", 32'(nrd + nwr), 32'd0);
    run(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    chk("err_range", {lat[15:0], 15'd0, e}, {16'd1, 15'd0, 1'b1});
    chk("err_range_mem", 32'(nrd + nwr), 32'd0);
    run(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    chk("err_ld_f3", {lat[15:0], 15'd0, e}, {16'd1, 15'd0, 1'b1});
    run(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    chk("err_st_f3", {lat[15:0], 15'd0, e}, {16'd1, 15'd0, 1'b1});
    chk("err_st_f3_mem", 32'(nrd + nwr), 32'd0);
    chk("err_rdata_hold", rdata, 32'hFFFFFF80);
    chk("err_mem2_intact", mem[2], 32'hCAFEAB44);

    // req held high: second accept only in the idle cycle after DONE
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_000C;
    ndone = 0; first_done = -1; second_done = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = i; else second_done = i;
      end
      if (i == 4) chk("b2b_idle_gap", 32'(busy), 32'd0);
      if (i == 8) req = 1'b0;
    end
    chk("b2b_done_count", 32'(ndone), 32'd2);
    chk("b2b_first_done", 32'(first_done), 32'd3);
    chk("b2b_second_done", 32'(second_done), 32'd7);
    chk("b2b_rdata", rdata, 32'h80FF7F01);

    // req pulses while busy and during DONE are dropped
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0010;
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
      req = (i <= 3) ? (i != 1) : 1'b0;
    end
    chk("busy_req_ignored", 32'(ndone), 32'd1);
    chk("busy_req_rdata", rdata, 32'hA5A55A5A);

    // Async reset in the write cycle of an SB must kill the write
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h0000_0008; wdata = 32'h77;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_memwrite", 32'(memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", 32'(memwrite), 32'd0);
    chk("rst_mid_strobes", {28'd0, busy, done, err, memread}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mem2_unchanged", mem[2], 32'hCAFEAB44);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
